temp_sched: RTL and testbench
=============================

# temp_sched

Sampling scheduler for the temperature path. It triggers periodic conversions on the MCP SPI ADC reader and averages a window of 2^AVG_LOG2 samples. It applies hysteresis to the average to drive the alarm LED demux, then hands the averaged value to the LCD writer over a req/ack handshake. It sits between the MCP reader, the LED demux and the LCD state machine in the top level.

## Interface
- PERIOD_CYC, 5000000, clk cycles between conversion triggers (100 ms at 50 MHz); ≥ 2
- AVG_LOG2, 2, log2 of samples per averaging window (0..4)
- HI_TH, 620, alarm set threshold (10-bit code)
- LO_TH, 600, alarm clear threshold (10-bit code); LO_TH < HI_TH
- TIMEOUT_CYC, 4096, max cycles to wait for a conversion result

- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- adc_start  out  1  one-cycle conversion request to the ADC reader
- adc_done  in  1  one-cycle pulse; adc_data valid in the same cycle
- adc_data  in  10  conversion result
- disp_req  out  1  display update request; held until acknowledged
- disp_ack  in  1  LCD writer accepted disp_val
- disp_val  out  10  averaged value; stable while disp_req=1
- alarm  out  1  hysteretic over-temperature flag, feeds the LED demux
- err  out  1  sticky: a conversion timed out
- ovr  out  1  sticky: a period tick was dropped

## Operation
- Period counter: free-running 0..PERIOD_CYC-1, independent of FSM state. tick=1 in the cycle count==PERIOD_CYC-1.
- Tick in IDLE starts a conversion. Tick in any other state sets `pend`, which is 1 deep. A tick arriving while `pend` is already 1 sets ovr.
- FSM states:
  - IDLE: if tick or pend, go to START and clear pend.
  - START: adc_start=1 for exactly this cycle; go to WAIT and clear the timeout counter.
  - WAIT: on adc_done, acc ← acc + adc_data and n ← n+1. If n was 2^AVG_LOG2−1, go to UPDATE; else go to IDLE.
  - WAIT timeout: if the timeout counter reaches TIMEOUT_CYC−1 with no adc_done, set err, clear acc and n, go to IDLE.
  - UPDATE: avg = acc >> AVG_LOG2 (truncating). Register disp_val ← avg. Alarm ← 1 if avg ≥ HI_TH; ← 0 if avg ≤ LO_TH; else hold. Set disp_req ← 1, clear acc and n, go to DISP.
  - DISP: hold disp_req and disp_val. When disp_ack=1 is sampled, disp_req ← 0 on that edge; go to IDLE.
- adc_done outside WAIT is ignored. disp_ack outside DISP is ignored.
- acc width is 10+AVG_LOG2, so it cannot overflow.
- err and ovr clear only on rst.

## Timing
- Reset (rst high at an edge) sets all outputs to 0, the FSM to IDLE, and acc, n, pend and both counters to 0. rst takes priority in every state, including mid-WAIT and mid-DISP. A pending disp_req is abandoned.
- First tick is in cycle PERIOD_CYC−1 after the reset edge. adc_start is high in the following cycle.
- All outputs are registered; none is combinationally dependent on inputs.
- Final adc_done in cycle t: UPDATE occurs in cycle t+1. disp_req, disp_val and alarm change at the end of t+1 and are visible in cycle t+2.
- disp_ack=1 in cycle k: disp_req=0 from cycle k+1. A conversion can start no earlier than k+2.
- adc_done in the same cycle as the timeout limit: the sample wins and no err is raised.
- Tick in the same cycle as the IDLE→START decision driven by pend: pend is re-set by that tick; no ovr.

## Test plan
Bench parameters: PERIOD_CYC=100, AVG_LOG2=2, HI_TH=620, LO_TH=600, TIMEOUT_CYC=50; the ADC model returns adc_done 20 cycles after adc_start.

1. **Reset and trigger cadence:** rst for 3 cycles, then free-run → all outputs 0 after reset; adc_start is a single-cycle pulse first at cycle 100 after the reset edge, then every 100 cycles.
2. **Averaging:** samples 610, 612, 614, 616 → one disp_req with disp_val=613, alarm=0. disp_req stays up until disp_ack, then drops the next cycle.
3. **Hysteresis:**
   - 620, 621, 622, 623 → disp_val=621, alarm=1.
   - 605 ×4 → alarm stays 1.
   - 600 ×4 → alarm=0.
   - 610 ×4 → alarm stays 0.
4. **Timeout:** no adc_done for the 3rd sample of a window → err=1 fifty cycles after WAIT is entered, no disp_req. The next window restarts at n=0; four good samples of 500 → disp_val=500.
5. **Backpressure:** hold disp_ack low for 250 cycles → disp_val stays constant and disp_req stays high. pend is set, then ovr=1 on the second tick. After disp_ack, adc_start occurs within 2 cycles.
6. **Reset mid-operation:** rst asserted in WAIT after 2 accumulated samples → on the next window, 4 samples of 700 yield disp_val=700 (no stale accumulation); err and ovr stay 0.

Source files
------------

// File: rtl/temp_sched.sv
// temp_sched -- sampling scheduler for the temperature path.
//
// A free-running period counter triggers conversions on the ADC reader.
// A window of 2^AVG_LOG2 results is summed and then averaged by truncation.
// A hysteretic alarm follows the average. The averaged value is offered
// to the LCD writer over a held req/ack handshake.
//
// Ports:
//   clk        system clock (only clock)
//   rst        synchronous, active-high reset
//   adc_start  out, one-cycle conversion request
//   adc_done   in,  one-cycle pulse, adc_data valid in the same cycle
//   adc_data   in,  10-bit conversion result
//   disp_req   out, display request, held until disp_ack
//   disp_ack   in,  LCD writer accepted disp_val
//   disp_val   out, averaged value, stable while disp_req=1
//   alarm      out, hysteretic over-temperature flag
//   err        out, sticky conversion-timeout flag
//   ovr        out, sticky dropped-tick flag
module temp_sched #(
    parameter int PERIOD_CYC  = 5000000,
    parameter int AVG_LOG2    = 2,
    parameter int HI_TH       = 620,
    parameter int LO_TH       = 600,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst,
    output logic       adc_start,
    input  logic       adc_done,
    input  logic [9:0] adc_data,
    output logic       disp_req,
    input  logic       disp_ack,
    output logic [9:0] disp_val,
    output logic       alarm,
    output logic       err,
    output logic       ovr
);

    localparam int PW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int AW = 10 + AVG_LOG2;
    localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    localparam logic [PW-1:0] PER_LAST = PW'(PERIOD_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [NW-1:0] N_LAST   = NW'((1 << AVG_LOG2) - 1);
    localparam logic [9:0]    HI_CODE  = 10'(HI_TH);
    localparam logic [9:0]    LO_CODE  = 10'(LO_TH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_UPDATE,
        ST_DISP
    } state_t;

    state_t        state_reg, state_next;
    logic [PW-1:0] per_cnt_reg;
    logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
    logic [AW-1:0] acc_reg, acc_next;
    logic [NW-1:0] n_reg, n_next;
    logic          pend_reg, pend_next;
    logic          adc_start_reg, adc_start_next;
    logic          disp_req_reg, disp_req_next;
    logic [9:0]    disp_val_reg, disp_val_next;
    logic          alarm_reg, alarm_next;
    logic          err_reg, err_next;
    logic          ovr_reg, ovr_next;

    logic          tick;
    logic [9:0]    avg;

    assign tick = (per_cnt_reg == PER_LAST);
    // The top 10 bits of the sum are exactly the truncated average.
    assign avg  = acc_reg[AVG_LOG2 +: 10];

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            per_cnt_reg   <= '0;
            tmo_cnt_reg   <= '0;
            acc_reg       <= '0;
            n_reg         <= '0;
            pend_reg      <= 1'b0;
            adc_start_reg <= 1'b0;
            disp_req_reg  <= 1'b0;
            disp_val_reg  <= '0;
            alarm_reg     <= 1'b0;
            err_reg       <= 1'b0;
            ovr_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            per_cnt_reg   <= tick ? '0 : per_cnt_reg + PW'(1);
            tmo_cnt_reg   <= tmo_cnt_next;
            acc_reg       <= acc_next;
            n_reg         <= n_next;
            pend_reg      <= pend_next;
            adc_start_reg <= adc_start_next;
            disp_req_reg  <= disp_req_next;
            disp_val_reg  <= disp_val_next;
            alarm_reg     <= alarm_next;
            err_reg       <= err_next;
            ovr_reg       <= ovr_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (tick || pend_reg) state_next = ST_START;
            ST_START:  state_next = ST_WAIT;
            ST_WAIT: begin
                // A result arriving on the timeout cycle still counts.
                if (adc_done)
                    state_next = (n_reg == N_LAST) ? ST_UPDATE : ST_IDLE;
                else if (tmo_cnt_reg == TMO_LAST)
                    state_next = ST_IDLE;
            end
            ST_UPDATE: state_next = ST_DISP;
            ST_DISP:   if (disp_ack) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Output / datapath next values (all registered above)
    always_comb begin
        tmo_cnt_next  = tmo_cnt_reg;
        acc_next      = acc_reg;
        n_next        = n_reg;
        pend_next     = pend_reg;
        disp_req_next = disp_req_reg;
        disp_val_next = disp_val_reg;
        alarm_next    = alarm_reg;
        err_next      = err_reg;
        ovr_next      = ovr_reg;

        // Registered copy of "in START next cycle" gives a glitch-free pulse.
        adc_start_next = (state_next == ST_START);

        // One-deep tick memory. Leaving IDLE on pend consumes it. A tick in
        // that same cycle re-arms it without counting as an overrun.
        if (state_reg == ST_IDLE) begin
            pend_next = pend_reg & tick;
        end else if (tick) begin
            pend_next = 1'b1;
            if (pend_reg) ovr_next = 1'b1;
        end

        case (state_reg)
            ST_START: tmo_cnt_next = '0;
            ST_WAIT: begin
                if (adc_done) begin
                    acc_next = acc_reg + AW'(adc_data);
                    n_next   = n_reg + NW'(1);
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    err_next = 1'b1;
                    acc_next = '0;
                    n_next   = '0;
                end else begin
                    tmo_cnt_next = tmo_cnt_reg + TW'(1);
                end
            end
            ST_UPDATE: begin
                disp_val_next = avg;
                if (avg >= HI_CODE)
                    alarm_next = 1'b1;
                else if (avg <= LO_CODE)
                    alarm_next = 1'b0;
                disp_req_next = 1'b1;
                acc_next      = '0;
                n_next        = '0;
            end
            ST_DISP: if (disp_ack) disp_req_next = 1'b0;
            default: ;
        endcase
    end

    assign adc_start = adc_start_reg;
    assign disp_req  = disp_req_reg;
    assign disp_val  = disp_val_reg;
    assign alarm     = alarm_reg;
    assign err       = err_reg;
    assign ovr       = ovr_reg;

endmodule

// File: tb/tb_temp_sched.sv
// tb_temp_sched -- directed bench for temp_sched. The ADC model answers
// 20 cycles after each adc_start with the next queued value. A value of -1
// means the model never answers. The LCD side is driven from the main
// sequence.
module tb_temp_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       adc_start;
    logic       adc_done;
    logic [9:0] adc_data;
    logic       disp_req;
    logic       disp_ack;
    logic [9:0] disp_val;
    logic       alarm;
    logic       err;
    logic       ovr;

    temp_sched #(
        .PERIOD_CYC (100),
        .AVG_LOG2   (2),
        .HI_TH      (620),
        .LO_TH      (600),
        .TIMEOUT_CYC(50)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .adc_start(adc_start),
        .adc_done (adc_done),
        .adc_data (adc_data),
        .disp_req (disp_req),
        .disp_ack (disp_ack),
        .disp_val (disp_val),
        .alarm    (alarm),
        .err      (err),
        .ovr      (ovr)
    );

    always #5 clk = ~clk;

    // cyc == c during cycle c after the most recent reset edge
    int cyc;
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ADC reader model
    int adc_q[$];
    int start_cyc_q[$];
    int drop_cnt = 0;
    int drop_start_cyc = 0;

    initial begin
        int v;
        adc_done = 1'b0;
        adc_data = '0;
        forever begin
            @(negedge clk);
            if (adc_start === 1'b1) begin
                start_cyc_q.push_back(cyc);
                v = (adc_q.size() > 0) ? adc_q.pop_front() : -1;
                if (v < 0) begin
                    drop_cnt++;
                    drop_start_cyc = cyc;
                end else begin
                    repeat (20) @(posedge clk);
                    #1;
                    adc_done = 1'b1;
                    adc_data = v[9:0];
                    @(posedge clk);
                    #1;
                    adc_done = 1'b0;
                end
            end
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_disp(input string tag, input int exp_val, input int exp_alarm);
        int t;
        t = 0;
        while (disp_req !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check({tag, " req"}, int'(disp_req), 1);
        check({tag, " val"}, int'(disp_val), exp_val);
        check({tag, " alarm"}, int'(alarm), exp_alarm);
        $display("window %s: disp_val=%0d alarm=%0d cycle=%0d", tag, disp_val, alarm, cyc);
    endtask

    task automatic ack_disp(input string tag, input int hold);
        int bad;
        int v0;
        bad = 0;
        v0  = int'(disp_val);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (disp_req !== 1'b1 || int'(disp_val) != v0) bad++;
        end
        check({tag, " hold"}, bad, 0);
        disp_ack = 1'b1;
        @(posedge clk);
        #1;
        disp_ack = 1'b0;
        @(negedge clk);
        check({tag, " req drop"}, int'(disp_req), 0);
    endtask

    initial begin
        int t;
        int bad;
        int v0;
        int found;

        rst      = 1'b1;
        disp_ack = 1'b0;

        adc_q = {610, 612, 614, 616,
                 620, 621, 622, 623};
        for (int i = 0; i < 4; i++) adc_q.push_back(605);
        for (int i = 0; i < 4; i++) adc_q.push_back(600);
        for (int i = 0; i < 4; i++) adc_q.push_back(610);
        adc_q.push_back(300); adc_q.push_back(300); adc_q.push_back(-1);
        for (int i = 0; i < 4; i++) adc_q.push_back(500);
        for (int i = 0; i < 4; i++) adc_q.push_back(630);
        adc_q.push_back(100); adc_q.push_back(100); adc_q.push_back(-1);
        for (int i = 0; i < 4; i++) adc_q.push_back(700);

        // Reset and trigger cadence
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst adc_start", int'(adc_start), 0);
        check("rst disp_req", int'(disp_req), 0);
        check("rst disp_val", int'(disp_val), 0);
        check("rst alarm", int'(alarm), 0);
        check("rst err", int'(err), 0);
        check("rst ovr", int'(ovr), 0);
        wait_cyc(99);
        check("adc_start@99", int'(adc_start), 0);
        @(negedge clk);
        check("adc_start@100", int'(adc_start), 1);
        @(negedge clk);
        check("adc_start@101", int'(adc_start), 0);

        // Averaging
        wait_disp("avg", 613, 0);
        check("avg req cycle", cyc, 422);
        ack_disp("avg", 5);
        check("start count", start_cyc_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < start_cyc_q.size()) check("start cadence", start_cyc_q[i], 100 * (i + 1));

        // Hysteresis
        wait_disp("hys rise", 621, 1);
        ack_disp("hys rise", 3);
        wait_disp("hys 605", 605, 1);
        ack_disp("hys 605", 3);
        wait_disp("hys 600", 600, 0);
        ack_disp("hys 600", 3);
        wait_disp("hys 610", 610, 0);
        ack_disp("hys 610", 3);

        // Timeout on the third sample of a window
        t = 0;
        while (err !== 1'b1 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("err set", int'(err), 1);
        check("err latency", cyc - drop_start_cyc, 51);
        check("no req on timeout", int'(disp_req), 0);
        $display("timeout: err=%0d at cycle %0d", err, cyc);
        wait_disp("after tmo", 500, 0);
        ack_disp("after tmo", 3);

        // Backpressure: two ticks land while DISP is held
        wait_disp("bp", 630, 1);
        bad = 0;
        v0  = int'(disp_val);
        for (int i = 1; i <= 250; i++) begin
            @(negedge clk);
            if (disp_req !== 1'b1 || int'(disp_val) != v0) bad++;
            if (i == 100) check("ovr before 2nd tick", int'(ovr), 0);
            if (i == 250) check("ovr after 2nd tick", int'(ovr), 1);
        end
        check("bp hold", bad, 0);
        disp_ack = 1'b1;
        @(posedge clk);
        #1;
        disp_ack = 1'b0;
        found = 0;
        for (int off = 1; off <= 3; off++) begin
            @(negedge clk);
            if (off == 1) check("bp req drop", int'(disp_req), 0);
            if (adc_start === 1'b1 && found == 0) found = off;
        end
        check("bp start latency", found, 2);
        $display("backpressure: ovr=%0d restart offset=%0d", ovr, found);

        // Reset in WAIT with two samples accumulated
        t = 0;
        while (drop_cnt < 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reached 2nd drop", drop_cnt, 2);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst adc_start", int'(adc_start), 0);
        check("midrst disp_req", int'(disp_req), 0);
        check("midrst disp_val", int'(disp_val), 0);
        check("midrst alarm", int'(alarm), 0);
        check("midrst err", int'(err), 0);
        check("midrst ovr", int'(ovr), 0);
        wait_disp("post rst", 700, 1);
        check("post rst req cycle", cyc, 422);
        ack_disp("post rst", 3);
        check("post rst err", int'(err), 0);
        check("post rst ovr", int'(ovr), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
